pixel_word_fifo: RTL and testbench

Elastic buffer between the cellular-RAM synchronous-read controller and the VGA pixel output in the image viewer. It accepts 16-bit words read from PSRAM, stores them in a first-word-fall-through FIFO, and unpacks each word into two 8-bit RGB332 pixels at the VGA pixel rate. It asks the memory side for more data when it runs low, and flags underflow when the display outruns memory.

---
 rtl/pixel_word_fifo_if.sv | 40 ++++
 rtl/pixel_word_fifo.sv | 133 +++++++++++++
 tb/tb_pixel_word_fifo.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_word_fifo_if.sv
// Bundle of signals between the pixel word FIFO, the PSRAM read side and the
// VGA pixel side.
//   master : the surroundings (memory reader + VGA timing) that push words,
//            request pixels and issue the frame-start flush
//   slave  : the FIFO itself
// Signals:
//   flush      frame-start clear, one cycle
//   wr_valid   memory side presents wr_data
//   wr_data    16-bit word, [15:8] first pixel, [7:0] second pixel
//   wr_ready   FIFO can take a word this cycle
//   fill_req   level at or below the low-water mark
//   level      words currently stored (0..2^DEPTH_LOG2)
//   pix_req    VGA consumes one pixel
//   pix_data   RGB332 pixel, registered
//   pix_valid  pix_data holds a real pixel this cycle
//   underflow  sticky flag, pixel requested while empty
interface pixel_word_fifo_if #(
    parameter int DEPTH_LOG2 = 5
);
    logic                  flush;
    logic                  wr_valid;
    logic [15:0]           wr_data;
    logic                  wr_ready;
    logic                  fill_req;
    logic [DEPTH_LOG2:0]   level;
    logic                  pix_req;
    logic [7:0]            pix_data;
    logic                  pix_valid;
    logic                  underflow;

    modport master (
        output flush, wr_valid, wr_data, pix_req,
        input  wr_ready, fill_req, level, pix_data, pix_valid, underflow
    );

    modport slave (
        input  flush, wr_valid, wr_data, pix_req,
        output wr_ready, fill_req, level, pix_data, pix_valid, underflow
    );
endinterface

// File: rtl/pixel_word_fifo.sv
// Elastic buffer between the PSRAM synchronous-read controller and the VGA
// pixel output. 16-bit words are stored in a first-word-fall-through FIFO and
// each word is unpacked into two RGB332 pixels, high byte first.
// Ports:
//   ClkPort  system clock, all state on its rising edge
//   Reset_n  synchronous active-low reset
//   bus      pixel_word_fifo_if slave modport (write side, pixel side,
//            flush, status)
module pixel_word_fifo #(
    parameter int DEPTH_LOG2 = 5,
    parameter int LOW_WATER  = 8
) (
    input  logic             ClkPort,
    input  logic             Reset_n,
    pixel_word_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL_C = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LOW_WATER_C  = (DEPTH_LOG2 + 1)'(LOW_WATER);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE_C  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE_C    = {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};

    logic [15:0]           mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   level_r;
    logic                  phase_r;
    logic [7:0]            pix_data_r;
    logic                  pix_valid_r;
    logic                  underflow_r;
    logic                  wr_ready_r;
    logic                  fill_req_r;

    logic                  push_s;
    logic                  serve_s;
    logic                  pop_s;
    logic                  empty_req_s;
    logic [15:0]           head_s;
    logic [7:0]            pix_byte_s;
    logic [DEPTH_LOG2:0]   level_next_s;

    // Handshake decode, head-of-queue byte select and next fill level.
    always_comb begin
        push_s       = 1'b0;
        serve_s      = 1'b0;
        pop_s        = 1'b0;
        empty_req_s  = 1'b0;
        head_s       = mem_r[rd_ptr_r];
        pix_byte_s   = 8'h00;
        level_next_s = level_r;

        push_s      = bus.wr_valid && wr_ready_r && !bus.flush;
        serve_s     = bus.pix_req && (level_r != {(DEPTH_LOG2 + 1){1'b0}}) && !bus.flush;
        // The word leaves the FIFO only once its second pixel is served.
        pop_s       = serve_s && phase_r;
        empty_req_s = bus.pix_req && (level_r == {(DEPTH_LOG2 + 1){1'b0}}) && !bus.flush;

        if (phase_r) begin
            pix_byte_s = head_s[7:0];
        end else begin
            pix_byte_s = head_s[15:8];
        end

        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LEVEL_ONE_C;
            2'b01:   level_next_s = level_r - LEVEL_ONE_C;
            default: level_next_s = level_r;
        endcase
    end

    // Word storage; contents are don't-care after reset or flush.
    always_ff @(posedge ClkPort) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.wr_data;
        end
    end

    // Pointers, level, byte phase, pixel output and status flags.
    always_ff @(posedge ClkPort) begin
        if (!Reset_n) begin
            wr_ptr_r    <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r    <= {DEPTH_LOG2{1'b0}};
            level_r     <= {(DEPTH_LOG2 + 1){1'b0}};
            phase_r     <= 1'b0;
            pix_data_r  <= 8'h00;
            pix_valid_r <= 1'b0;
            underflow_r <= 1'b0;
            wr_ready_r  <= 1'b1;
            fill_req_r  <= 1'b1;
        end else if (bus.flush) begin
            // Frame start: drop everything; pix_data keeps its last value.
            wr_ptr_r    <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r    <= {DEPTH_LOG2{1'b0}};
            level_r     <= {(DEPTH_LOG2 + 1){1'b0}};
            phase_r     <= 1'b0;
            pix_valid_r <= 1'b0;
            underflow_r <= 1'b0;
            wr_ready_r  <= 1'b1;
            fill_req_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            level_r <= level_next_s;
            // Status flags are registered from the next level so they track
            // the stored level with no extra cycle of lag.
            wr_ready_r <= (level_next_s != FULL_LEVEL_C);
            fill_req_r <= (level_next_s <= LOW_WATER_C);

            if (serve_s) begin
                pix_data_r  <= pix_byte_s;
                pix_valid_r <= 1'b1;
                phase_r     <= ~phase_r;
            end else if (empty_req_s) begin
                pix_data_r  <= 8'h00;
                pix_valid_r <= 1'b0;
                underflow_r <= 1'b1;
            end else begin
                pix_valid_r <= 1'b0;
            end
        end
    end

    assign bus.wr_ready  = wr_ready_r;
    assign bus.fill_req  = fill_req_r;
    assign bus.level     = level_r;
    assign bus.pix_data  = pix_data_r;
    assign bus.pix_valid = pix_valid_r;
    assign bus.underflow = underflow_r;
endmodule

// File: tb/tb_pixel_word_fifo.sv
// Directed self-checking bench for pixel_word_fifo. Inputs change 1 time unit
// after a rising edge, outputs are sampled at the same point.
module tb_pixel_word_fifo;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    pixel_word_fifo_if #(.DEPTH_LOG2(5)) bus ();

    pixel_word_fifo #(.DEPTH_LOG2(5), .LOW_WATER(8)) dut (
        .ClkPort (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.flush    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 16'h0000;
        bus.pix_req  = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        vectors++;
        if (bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready got %b exp 1", bus.wr_ready); end
        vectors++;
        if (bus.fill_req !== 1'b1) begin miscompares++; $display("FAIL reset_fill_req got %b exp 1", bus.fill_req); end
        vectors++;
        if (bus.level !== 6'd0) begin miscompares++; $display("FAIL reset_level got %0d exp 0", bus.level); end
        vectors++;
        if (bus.pix_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pix_valid got %b exp 0", bus.pix_valid); end
        vectors++;
        if (bus.pix_data !== 8'h00) begin miscompares++; $display("FAIL reset_pix_data got %h exp 00", bus.pix_data); end
        vectors++;
        if (bus.underflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow got %b exp 0", bus.underflow); end
    endtask

    task automatic test_unpack();
        logic [7:0] exp_bytes [4];
        exp_bytes[0] = 8'hA1; exp_bytes[1] = 8'hB2; exp_bytes[2] = 8'hC3; exp_bytes[3] = 8'hD4;
        bus.wr_valid = 1'b1; bus.wr_data = 16'hA1B2; tick();
        bus.wr_data = 16'hC3D4; tick();
        bus.wr_valid = 1'b0;
        vectors++;
        if (bus.level !== 6'd2) begin miscompares++; $display("FAIL unpack_level_pre got %0d exp 2", bus.level); end
        bus.pix_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (bus.pix_data !== exp_bytes[k] || bus.pix_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL unpack_pix%0d got %h/%b exp %h/1", k, bus.pix_data, bus.pix_valid, exp_bytes[k]);
            end
        end
        bus.pix_req = 1'b0;
        vectors++;
        if (bus.level !== 6'd0) begin miscompares++; $display("FAIL unpack_level_post got %0d exp 0", bus.level); end
    endtask

    task automatic test_full();
        logic [7:0] exp_b;
        for (int i = 0; i < 33; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 16'(i);
            tick();
            if (i == 30) begin
                vectors++;
                if (bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready31 got %b exp 1", bus.wr_ready); end
            end
            if (i == 31) begin
                vectors++;
                if (bus.wr_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready32 got %b exp 0", bus.wr_ready); end
            end
        end
        bus.wr_valid = 1'b0;
        vectors++;
        if (bus.level !== 6'd32) begin miscompares++; $display("FAIL full_level got %0d exp 32", bus.level); end
        vectors++;
        if (bus.fill_req !== 1'b0) begin miscompares++; $display("FAIL full_fill_req got %b exp 0", bus.fill_req); end
        bus.pix_req = 1'b1;
        for (int k = 0; k < 64; k++) begin
            tick();
            exp_b = (k % 2 == 1) ? 8'(k / 2) : 8'h00;
            vectors++;
            if (bus.pix_data !== exp_b || bus.pix_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL full_drain%0d got %h/%b exp %h/1", k, bus.pix_data, bus.pix_valid, exp_b);
            end
        end
        bus.pix_req = 1'b0;
        vectors++;
        if (bus.level !== 6'd0) begin miscompares++; $display("FAIL full_level_post got %0d exp 0", bus.level); end
    endtask

    task automatic test_underflow();
        bus.pix_req = 1'b1; tick();
        bus.pix_req = 1'b0;
        vectors++;
        if (bus.pix_valid !== 1'b0 || bus.pix_data !== 8'h00 || bus.underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow_hit got v=%b d=%h u=%b exp v=0 d=00 u=1", bus.pix_valid, bus.pix_data, bus.underflow);
        end
        tick();
        vectors++;
        if (bus.underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_hold got %b exp 1", bus.underflow); end
        bus.wr_valid = 1'b1; bus.wr_data = 16'h1234; tick();
        bus.wr_valid = 1'b0; bus.pix_req = 1'b1; tick();
        bus.pix_req = 1'b0;
        vectors++;
        if (bus.pix_data !== 8'h12 || bus.pix_valid !== 1'b1 || bus.underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow_recover got d=%h v=%b u=%b exp d=12 v=1 u=1", bus.pix_data, bus.pix_valid, bus.underflow);
        end
    endtask

    task automatic test_back_to_back();
        // Level 1, phase 1, head 16'h1234 left over from the underflow test.
        bus.wr_valid = 1'b1; bus.wr_data = 16'h5566; bus.pix_req = 1'b1; tick();
        bus.wr_valid = 1'b0;
        vectors++;
        if (bus.pix_data !== 8'h34 || bus.pix_valid !== 1'b1) begin
            miscompares++; $display("FAIL b2b_low got %h/%b exp 34/1", bus.pix_data, bus.pix_valid);
        end
        vectors++;
        if (bus.level !== 6'd1) begin miscompares++; $display("FAIL b2b_level got %0d exp 1", bus.level); end
        tick();
        vectors++;
        if (bus.pix_data !== 8'h55) begin miscompares++; $display("FAIL b2b_next_hi got %h exp 55", bus.pix_data); end
        tick();
        bus.pix_req = 1'b0;
        vectors++;
        if (bus.pix_data !== 8'h66) begin miscompares++; $display("FAIL b2b_next_lo got %h exp 66", bus.pix_data); end
        vectors++;
        if (bus.level !== 6'd0) begin miscompares++; $display("FAIL b2b_level_post got %0d exp 0", bus.level); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 11; i++) begin
            bus.wr_valid = 1'b1; bus.wr_data = 16'h0100 + 16'(i); tick();
        end
        bus.wr_valid = 1'b0;
        // Three pixels: one word popped, phase left at 1.
        bus.pix_req = 1'b1; tick(); tick(); tick();
        bus.pix_req = 1'b0;
        vectors++;
        if (bus.pix_data !== 8'h01) begin miscompares++; $display("FAIL flush_pre_data got %h exp 01", bus.pix_data); end
        vectors++;
        if (bus.level !== 6'd10 || bus.underflow !== 1'b1 || bus.fill_req !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_pre got lvl=%0d u=%b f=%b exp lvl=10 u=1 f=0", bus.level, bus.underflow, bus.fill_req);
        end
        bus.flush = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 16'hDEAD; bus.pix_req = 1'b1; tick();
        bus.flush = 1'b0; bus.wr_valid = 1'b0; bus.pix_req = 1'b0;
        vectors++;
        if (bus.level !== 6'd0 || bus.underflow !== 1'b0 || bus.pix_valid !== 1'b0 || bus.fill_req !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_state got lvl=%0d u=%b v=%b f=%b exp 0/0/0/1", bus.level, bus.underflow, bus.pix_valid, bus.fill_req);
        end
        bus.wr_valid = 1'b1; bus.wr_data = 16'hBEEF; tick();
        bus.wr_valid = 1'b0; bus.pix_req = 1'b1; tick();
        vectors++;
        if (bus.pix_data !== 8'hBE || bus.pix_valid !== 1'b1) begin
            miscompares++; $display("FAIL flush_phase got %h/%b exp BE/1", bus.pix_data, bus.pix_valid);
        end
        tick();
        bus.pix_req = 1'b0;
        vectors++;
        if (bus.pix_data !== 8'hEF) begin miscompares++; $display("FAIL flush_second got %h exp EF", bus.pix_data); end
        vectors++;
        if (bus.level !== 6'd0) begin miscompares++; $display("FAIL flush_level_post got %0d exp 0", bus.level); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_unpack();
        test_full();
        test_underflow();
        test_back_to_back();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
